// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory stage: control-word layout, wb_src and funct3
// codes, access sizes and the load/store FSM states.
package riscv_mem_pkg;

    // control_word_ex = {branch_taken, rf_wb, mem_we, wb_src[1:0], pc_src, rd[4:0], funct3[2:0]}
    localparam int CW_WIDTH     = 14;
    localparam int CW_BRANCH    = 13;
    localparam int CW_RF_WB     = 12;
    localparam int CW_MEM_WE    = 11;
    localparam int CW_WB_SRC_LO = 9;
    localparam int CW_PC_SRC    = 8;
    localparam int CW_RD_LO     = 3;
    localparam int CW_F3_LO     = 0;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_ADR  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } mem_state_e;

    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data-memory port: byte enables, store replication,
// load extraction with sign/zero extension, and misalignment detection.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  adr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        misalign,
    output logic [1:0]  lo_eff,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [1:0]  size;
    logic [31:0] shifted;

    assign size = access_size(funct3);

    always_comb begin
        misalign = 1'b0;
        lo_eff   = adr_lo;
        be       = 4'b1111;
        wdata    = store_data;
        case (size)
            SZ_BYTE: begin
                lo_eff = adr_lo;
                be     = 4'b0001 << adr_lo;
                wdata  = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                misalign = adr_lo[0];
                lo_eff   = {adr_lo[1], 1'b0};
                be       = 4'b0011 << {adr_lo[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
            end
            default: begin
                misalign = (adr_lo != 2'b00);
                lo_eff   = 2'b00;
                be       = 4'b1111;
                wdata    = store_data;
            end
        endcase
    end

    // Lane offset uses the forced-aligned address so unchecked accesses stay in-word.
    assign shifted = rdata >> {lo_eff, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'b0, shifted[7:0]};
            F3_LHU:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM register, single-outstanding data-memory access
// FSM, and the MEM/WB register feeding write-back.
//
// state  | meaning
// IDLE   | no access in flight; request issued here for a held memory op
// WAIT_R | load granted, waiting for rvalid (request deasserted)
module memory_stage
    import riscv_mem_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_ex,
    input  logic [13:0] control_word_ex,
    input  logic [31:0] calculated_adr,
    input  logic [31:0] pc_plus_4_ex,
    input  logic [31:0] ALU_result,
    input  logic [31:0] regfileb_ex,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_rf_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err
);

    logic        valid_q;
    logic        rf_wb_q;
    logic        mem_we_q;
    logic [1:0]  wb_src_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [31:0] adr_q;
    logic [31:0] pc4_q;
    logic [31:0] alu_q;
    logic [31:0] rs2_q;

    mem_state_e  state;

    logic        is_load;
    logic        is_store;
    logic        memop;
    logic        misalign;
    logic        drop;
    logic        req;
    logic        complete;
    logic [1:0]  lo_eff;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic [31:0] wb_next;

    // Branch/PC-select bits are consumed upstream; this stage only forwards data.
    logic unused_ctrl;
    assign unused_ctrl = control_word_ex[CW_BRANCH] ^ control_word_ex[CW_PC_SRC] ^ lo_eff[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            rf_wb_q  <= 1'b0;
            mem_we_q <= 1'b0;
            wb_src_q <= 2'b00;
            rd_q     <= 5'd0;
            f3_q     <= 3'd0;
            adr_q    <= 32'd0;
            pc4_q    <= 32'd0;
            alu_q    <= 32'd0;
            rs2_q    <= 32'd0;
        end else if (!stall_mem) begin
            valid_q  <= valid_ex;
            rf_wb_q  <= control_word_ex[CW_RF_WB];
            mem_we_q <= control_word_ex[CW_MEM_WE];
            wb_src_q <= control_word_ex[CW_WB_SRC_LO +: 2];
            rd_q     <= control_word_ex[CW_RD_LO +: 5];
            f3_q     <= control_word_ex[CW_F3_LO +: 3];
            adr_q    <= calculated_adr;
            pc4_q    <= pc_plus_4_ex;
            alu_q    <= ALU_result;
            rs2_q    <= regfileb_ex;
        end
    end

    lsu_align u_lsu_align (
        .adr_lo     (adr_q[1:0]),
        .funct3     (f3_q),
        .store_data (rs2_q),
        .rdata      (dmem_rdata),
        .misalign   (misalign),
        .lo_eff     (lo_eff),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    assign is_store = mem_we_q;
    assign is_load  = !mem_we_q && (wb_src_q == WB_LOAD);
    assign memop    = is_store || is_load;
    assign drop     = CHECK_ALIGN && valid_q && memop && misalign && (state == IDLE);
    assign req      = (state == IDLE) && valid_q && memop && !drop;

    always_comb begin
        complete = 1'b0;
        case (state)
            IDLE:    complete = drop || (req && dmem_gnt && is_store);
            WAIT_R:  complete = dmem_rvalid;
            default: complete = 1'b0;
        endcase
    end

    assign stall_mem    = valid_q && memop && !complete;
    assign misalign_err = drop;

    // Request fields are gated by req so the port reads all-zero when idle.
    assign dmem_req   = req;
    assign dmem_we    = req && is_store;
    assign dmem_addr  = req ? {adr_q[31:2], 2'b00} : 32'd0;
    assign dmem_be    = req ? be : 4'd0;
    assign dmem_wdata = req ? wdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req && dmem_gnt && is_load)
                        state <= WAIT_R;
                end
                WAIT_R: begin
                    if (dmem_rvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb_next = alu_q;
        case (wb_src_q)
            WB_ALU:  wb_next = alu_q;
            WB_LOAD: wb_next = load_data;
            WB_PC4:  wb_next = pc4_q;
            WB_ADR:  wb_next = adr_q;
            default: wb_next = alu_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_rf_we <= 1'b0;
            wb_rd    <= 5'd0;
            wb_data  <= 32'd0;
        end else if (stall_mem || !valid_q) begin
            wb_valid <= 1'b0;
            wb_rf_we <= 1'b0;
        end else begin
            wb_valid <= 1'b1;
            wb_rf_we <= rf_wb_q && !drop;
            wb_rd    <= rd_q;
            wb_data  <= wb_next;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a table of single-instruction vectors plus
// hand sequences for reset during WAIT_R and back-to-back store/load.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_ex;
    logic [13:0] control_word_ex;
    logic [31:0] calculated_adr;
    logic [31:0] pc_plus_4_ex;
    logic [31:0] ALU_result;
    logic [31:0] regfileb_ex;
    logic        stall_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_rf_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;

    int n_cmp = 0;
    int n_bad = 0;

    memory_stage #(.CHECK_ALIGN(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_ex        (valid_ex),
        .control_word_ex (control_word_ex),
        .calculated_adr  (calculated_adr),
        .pc_plus_4_ex    (pc_plus_4_ex),
        .ALU_result      (ALU_result),
        .regfileb_ex     (regfileb_ex),
        .stall_mem       (stall_mem),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_gnt        (dmem_gnt),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata),
        .wb_valid        (wb_valid),
        .wb_rf_we        (wb_rf_we),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rf_wb;
        logic        mem_we;
        logic [1:0]  wb_src;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] adr;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis;
        int          e_stall;
        logic        e_we;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic rf_wb, input logic mem_we, input logic [1:0] wb_src,
        input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] adr, input logic [31:0] pc4,
        input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] rdata,
        input int gnt_dly, input int rv_dly, input logic e_req, input logic [31:0] e_addr,
        input logic [3:0] e_be, input logic [31:0] e_wdata, input logic e_mis, input int e_stall,
        input logic e_we, input logic [31:0] e_data);
        vec_t v;
        v.name = nm; v.rf_wb = rf_wb; v.mem_we = mem_we; v.wb_src = wb_src; v.rd = rd; v.f3 = f3;
        v.adr = adr; v.pc4 = pc4; v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
        v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.e_req = e_req; v.e_addr = e_addr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_mis = e_mis; v.e_stall = e_stall; v.e_we = e_we; v.e_data = e_data;
        return v;
    endfunction

    task automatic drive(input logic rf_wb, input logic mem_we, input logic [1:0] wb_src,
                         input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] adr,
                         input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] rs2);
        valid_ex        = 1'b1;
        control_word_ex = {1'b0, rf_wb, mem_we, wb_src, 1'b0, rd, f3};
        calculated_adr  = adr;
        pc_plus_4_ex    = pc4;
        ALU_result      = alu;
        regfileb_ex     = rs2;
    endtask

    // Entered #1 after a rising edge with the stage empty.
    task automatic run_vec(input vec_t v);
        int   c;
        int   stalls;
        bit   done;
        bit   got_gnt;
        logic exp_req;
        drive(v.rf_wb, v.mem_we, v.wb_src, v.rd, v.f3, v.adr, v.pc4, v.alu, v.rs2);
        dmem_rdata = v.rdata;
        @(posedge clk); #1;
        valid_ex = 1'b0;
        c = 0; stalls = 0; done = 1'b0; got_gnt = 1'b0;
        while (!done && c < 20) begin
            dmem_gnt    = v.e_req && !got_gnt && (c == v.gnt_dly);
            dmem_rvalid = v.e_req && !v.mem_we && (c == v.gnt_dly + 1 + v.rv_dly);
            @(negedge clk);
            exp_req = v.e_req && (c <= v.gnt_dly);
            chk({v.name, " req"}, dmem_req, exp_req);
            if (exp_req) begin
                chk({v.name, " addr"}, dmem_addr, v.e_addr);
                chk({v.name, " be"}, dmem_be, v.e_be);
                chk({v.name, " wdata"}, dmem_wdata, v.e_wdata);
                chk({v.name, " we"}, dmem_we, v.mem_we);
            end
            if (c == 0) chk({v.name, " misalign_err"}, misalign_err, v.e_mis);
            else        chk({v.name, " bubble during stall"}, wb_valid, 1'b0);
            if (dmem_gnt) got_gnt = 1'b1;
            if (stall_mem) stalls++;
            else           done = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: stall still high after %0d cycles", v.name, c);
        end
        chk({v.name, " stall cycles"}, stalls, v.e_stall);
        chk({v.name, " wb_valid"}, wb_valid, 1'b1);
        chk({v.name, " wb_rf_we"}, wb_rf_we, v.e_we);
        chk({v.name, " wb_rd"}, wb_rd, v.rd);
        if (v.e_we) chk({v.name, " wb_data"}, wb_data, v.e_data);
        @(posedge clk); #1;
        chk({v.name, " wb bubble after"}, wb_valid, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " stall_mem"}, stall_mem, 1'b0);
        chk({nm, " dmem_req"}, dmem_req, 1'b0);
        chk({nm, " dmem_we"}, dmem_we, 1'b0);
        chk({nm, " dmem_addr"}, dmem_addr, 32'd0);
        chk({nm, " dmem_be"}, dmem_be, 4'd0);
        chk({nm, " dmem_wdata"}, dmem_wdata, 32'd0);
        chk({nm, " wb_valid"}, wb_valid, 1'b0);
        chk({nm, " wb_rf_we"}, wb_rf_we, 1'b0);
        chk({nm, " wb_rd"}, wb_rd, 5'd0);
        chk({nm, " wb_data"}, wb_data, 32'd0);
        chk({nm, " misalign_err"}, misalign_err, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; valid_ex = 1'b0; control_word_ex = '0; calculated_adr = '0;
        pc_plus_4_ex = '0; ALU_result = '0; regfileb_ex = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        //          name     rfwb we  src    rd  f3      adr           pc4    alu     rs2           rdata         gd rd req addr          be       wdata         mis st we data
        vecs.push_back(mk("alu",   1, 0, 2'b00, 5, 3'b000, 32'h0,        32'h0, 32'h1234, 32'h0,     32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 1, 32'h1234));
        vecs.push_back(mk("sb",    0, 1, 2'b00, 0, 3'b000, 32'h103,      32'h0, 32'h0,  32'hAB,      32'h0,        0, 0, 1, 32'h100,      4'b1000, 32'hABABABAB, 0, 0, 0, 32'h0));
        vecs.push_back(mk("lb",    1, 0, 2'b01, 7, 3'b000, 32'h102,      32'h0, 32'h0,  32'h0,       32'h00800000, 2, 0, 1, 32'h100,      4'b0100, 32'h0,        0, 3, 1, 32'hFFFFFF80));
        vecs.push_back(mk("lbu",   1, 0, 2'b01, 7, 3'b100, 32'h102,      32'h0, 32'h0,  32'h0,       32'h00800000, 2, 0, 1, 32'h100,      4'b0100, 32'h0,        0, 3, 1, 32'h00000080));
        vecs.push_back(mk("lw_mis",1, 0, 2'b01, 8, 3'b010, 32'h102,      32'h0, 32'h0,  32'h0,       32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk("lh",    1, 0, 2'b01, 9, 3'b001, 32'h102,      32'h0, 32'h0,  32'h0,       32'h80010000, 0, 0, 1, 32'h100,      4'b1100, 32'h0,        0, 1, 1, 32'hFFFF8001));
        vecs.push_back(mk("lhu",   1, 0, 2'b01, 10,3'b101, 32'h100,      32'h0, 32'h0,  32'h0,       32'h1234F00D, 1, 1, 1, 32'h100,      4'b0011, 32'h0,        0, 3, 1, 32'h0000F00D));
        vecs.push_back(mk("sh",    0, 1, 2'b00, 0, 3'b001, 32'h202,      32'h0, 32'h0,  32'hDEADBEEF,32'h0,        1, 0, 1, 32'h200,      4'b1100, 32'hBEEFBEEF, 0, 1, 0, 32'h0));
        vecs.push_back(mk("sw",    0, 1, 2'b00, 0, 3'b010, 32'h300,      32'h0, 32'h0,  32'hCAFEBABE,32'h0,        0, 0, 1, 32'h300,      4'b1111, 32'hCAFEBABE, 0, 0, 0, 32'h0));
        vecs.push_back(mk("pc4",   1, 0, 2'b10, 1, 3'b000, 32'h0,        32'h44,32'h99, 32'h0,       32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 1, 32'h44));
        vecs.push_back(mk("auipc_x0",1,0,2'b11, 0, 3'b000, 32'h80001000, 32'h0, 32'h0,  32'h0,       32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 1, 32'h80001000));
        vecs.push_back(mk("sh_mis",0, 1, 2'b00, 0, 3'b001, 32'h101,      32'h0, 32'h0,  32'h5555,    32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        1, 0, 0, 32'h0));
        vecs.push_back(mk("lw",    1, 0, 2'b01, 31,3'b010, 32'h104,      32'h0, 32'h0,  32'h0,       32'h89ABCDEF, 0, 2, 1, 32'h104,      4'b1111, 32'h0,        0, 3, 1, 32'h89ABCDEF));

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("in reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("after reset");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while a load waits for rvalid; the late rvalid must be ignored.
        drive(1, 0, 2'b01, 5'd3, 3'b010, 32'h500, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        valid_ex = 1'b0;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("wait_r stall", stall_mem, 1'b1);
        chk("wait_r req low", dmem_req, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_all_zero("reset in wait_r");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0000FFFF;
        @(negedge clk);
        chk("late rvalid stall", stall_mem, 1'b0);
        chk("late rvalid req", dmem_req, 1'b0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("late rvalid no wb", wb_valid, 1'b0);
        chk("late rvalid no we", wb_rf_we, 1'b0);
        run_vec(vecs[0]);

        // Back-to-back SW then LW with gnt held high.
        dmem_gnt = 1'b1;
        drive(0, 1, 2'b00, 5'd0, 3'b010, 32'h400, 32'h0, 32'h0, 32'h11223344);
        @(posedge clk); #1;
        drive(1, 0, 2'b01, 5'd9, 3'b010, 32'h404, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b sw req", dmem_req, 1'b1);
        chk("b2b sw we", dmem_we, 1'b1);
        chk("b2b sw addr", dmem_addr, 32'h400);
        chk("b2b sw be", dmem_be, 4'b1111);
        chk("b2b sw wdata", dmem_wdata, 32'h11223344);
        chk("b2b sw stall", stall_mem, 1'b0);
        @(posedge clk); #1;
        valid_ex = 1'b0;
        @(negedge clk);
        chk("b2b lw req", dmem_req, 1'b1);
        chk("b2b lw we", dmem_we, 1'b0);
        chk("b2b lw addr", dmem_addr, 32'h404);
        chk("b2b lw stall", stall_mem, 1'b1);
        chk("b2b sw retired", wb_valid, 1'b1);
        chk("b2b sw no rf write", wb_rf_we, 1'b0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55667788;
        @(negedge clk);
        chk("b2b rvalid cycle req", dmem_req, 1'b0);
        chk("b2b rvalid cycle stall", stall_mem, 1'b0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b0;
        chk("b2b lw wb_valid", wb_valid, 1'b1);
        chk("b2b lw wb_rf_we", wb_rf_we, 1'b1);
        chk("b2b lw wb_rd", wb_rd, 5'd9);
        chk("b2b lw wb_data", wb_data, 32'h55667788);
        @(posedge clk); #1;
        chk("b2b idle req", dmem_req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
